// File: rtl/lab_pio_in_if.sv
// Avalon-MM slave bus bundle for the lab input PIO.
interface lab_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab_pio_in.sv
// Avalon-MM input PIO: synchronised, debounced board inputs with per-bit
// edge capture (W1C) and a maskable level interrupt.
module lab_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    lab_pio_in_if.slave      bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES == 0) ? '0 : CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_set, w1c;
    logic             wr_en;
    logic             unused_wdata;

    assign sync         = sync_q[SYNC_STAGES-1];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Any cycle where sync agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (DEBOUNCE_CYCLES == 0) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = stable_d & ~stable_q;
            1:       edge_set = stable_q & ~stable_d;
            default: edge_set = stable_d ^ stable_q;
        endcase
        w1c    = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
        mask_d = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
        // A capture landing on the same edge as its W1C clear must survive.
        edge_d = (edge_q & ~w1c) | edge_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable_q;
            2'd2:    bus.readdata[WIDTH-1:0] = mask_q;
            2'd3:    bus.readdata[WIDTH-1:0] = edge_q;
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_lab_pio_in.sv
// Bench for lab_pio_in: directed vector table, reset corner sequence and
// random traffic against a behavioural model (rising-edge and any-edge DUTs).
module tb_lab_pio_in;
    localparam int DEB = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = '0;
    logic       irq0, irq2;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    lab_pio_in_if bif0 ();
    lab_pio_in_if bif2 ();

    assign bif2.address    = bif0.address;
    assign bif2.chipselect = bif0.chipselect;
    assign bif2.write_n    = bif0.write_n;
    assign bif2.writedata  = bif0.writedata;

    lab_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bif0.slave), .in_port(in_port), .irq(irq0));

    lab_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .bus(bif2.slave), .in_port(in_port), .irq(irq2));

    // Behavioural model: a bit's new level is accepted once the synchronised
    // input has disagreed with the accepted level for DEB consecutive cycles.
    logic [3:0] m_s1, m_s2, m_stab, m_cap0, m_cap2, m_mask, m_ns, m_clr;
    int         m_run [4];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= '0; m_s2 <= '0; m_stab <= '0;
            m_cap0 <= '0; m_cap2 <= '0; m_mask <= '0;
            for (int b = 0; b < 4; b++) m_run[b] <= 0;
        end else begin
            m_ns = m_stab;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] != m_stab[b]) begin
                    if (m_run[b] + 1 == DEB) begin
                        m_ns[b] = m_s2[b];
                        m_run[b] <= 0;
                    end else begin
                        m_run[b] <= m_run[b] + 1;
                    end
                end else begin
                    m_run[b] <= 0;
                end
            end
            m_clr = (bif0.chipselect && !bif0.write_n && bif0.address == 2'd3) ? bif0.writedata[3:0] : 4'h0;
            m_cap0 <= (m_cap0 & ~m_clr) | (m_ns & ~m_stab);
            m_cap2 <= (m_cap2 & ~m_clr) | (m_ns ^ m_stab);
            if (bif0.chipselect && !bif0.write_n && bif0.address == 2'd2) m_mask <= bif0.writedata[3:0];
            m_stab <= m_ns;
            m_s2   <= m_s1;
            m_s1   <= in_port;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [3:0] st,
                                           input logic [3:0] mk, input logic [3:0] cp);
        case (a)
            2'd0:    return {28'd0, st};
            2'd2:    return {28'd0, mk};
            2'd3:    return {28'd0, cp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  in_val;
        bit          do_wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          waits;
        logic [1:0]  caddr;
        logic [31:0] rd0;
        bit          irq0;
        bit          chk2;
        logic [31:0] rd2;
        bit          irq2;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [3:0] iv, input bit w, input logic [1:0] wa,
                       input logic [31:0] wd, input int wt, input logic [1:0] ca,
                       input logic [31:0] r0, input bit i0, input bit c2,
                       input logic [31:0] r2, input bit i2);
        vec_t v;
        v.name = nm; v.in_val = iv; v.do_wr = w; v.waddr = wa; v.wdata = wd; v.waits = wt;
        v.caddr = ca; v.rd0 = r0; v.irq0 = i0; v.chk2 = c2; v.rd2 = r2; v.irq2 = i2;
        tbl.push_back(v);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a,
                          input logic [31:0] e0, input logic [31:0] e2);
        bif0.address = a;
        #1;
        chk({name, "/rd"}, bif0.readdata, e0);
        chk({name, "/rd_any"}, bif2.readdata, e2);
    endtask

    initial begin
        bif0.chipselect = 1'b0;
        bif0.write_n    = 1'b1;
        bif0.address    = 2'd0;
        bif0.writedata  = '0;

        //     name          in  wr wa wdata wt ca  rd0 i0 c2 rd2 i2
        add("rst_data",     0, 0, 0, 0,    0, 0,  0, 0, 1, 0, 0);
        add("rst_mask",     0, 0, 0, 0,    0, 2,  0, 0, 1, 0, 0);
        add("rst_cap",      0, 0, 0, 0,    0, 3,  0, 0, 1, 0, 0);
        add("ro_data",      0, 1, 0, 'hF,  1, 0,  0, 0, 1, 0, 0);
        add("rsv_read",     0, 1, 1, 'hF,  1, 1,  0, 0, 1, 0, 0);
        add("lat_m1",       1, 0, 0, 0,    5, 0,  0, 0, 1, 0, 0);
        add("lat_hit",      1, 0, 0, 0,    1, 0,  1, 0, 1, 1, 0);
        add("rise_cap",     1, 0, 0, 0,    0, 3,  1, 0, 1, 1, 0);
        add("glitch3",      3, 0, 0, 0,    3, 0,  1, 0, 1, 1, 0);
        add("glitch_rej",   1, 0, 0, 0,    8, 0,  1, 0, 1, 1, 0);
        add("glitch_cap",   1, 0, 0, 0,    0, 3,  1, 0, 1, 1, 0);
        add("hold4_pre",    3, 0, 0, 0,    4, 0,  1, 0, 1, 1, 0);
        add("hold4_mid",    1, 0, 0, 0,    1, 0,  1, 0, 1, 1, 0);
        add("hold4_acc",    1, 0, 0, 0,    1, 0,  3, 0, 1, 3, 0);
        add("hold4_cap",    1, 0, 0, 0,    0, 3,  3, 0, 1, 3, 0);
        add("bit1_fall",    1, 0, 0, 0,    6, 0,  1, 0, 1, 1, 0);
        add("fall1_cap",    1, 0, 0, 0,    0, 3,  3, 0, 1, 3, 0);
        add("mask_wr",      1, 1, 2, 1,    1, 2,  1, 1, 1, 1, 1);
        add("w1c_bit0",     1, 1, 3, 1,    1, 3,  2, 0, 1, 2, 0);
        add("fall0",        0, 0, 0, 0,    8, 0,  0, 0, 1, 0, 1);
        add("rise0",        1, 0, 0, 0,    6, 3,  3, 1, 1, 3, 1);
        add("fall0_b",      0, 0, 0, 0,    8, 3,  3, 1, 1, 3, 1);
        add("pre_set",      1, 0, 0, 0,    5, 0,  0, 1, 1, 0, 1);
        add("set_vs_clr",   1, 1, 3, 1,    1, 3,  3, 1, 1, 3, 1);
        add("clr_all",      1, 1, 3, 'hF,  1, 3,  0, 0, 1, 0, 0);
        add("fall_type",    0, 0, 0, 0,    8, 3,  0, 0, 1, 1, 1);
        add("fall_data",    0, 0, 0, 0,    0, 0,  0, 0, 1, 0, 1);

        // Reset held with inputs high: everything must read zero.
        in_port = 4'hF;
        repeat (3) @(negedge clk);
        rd_chk("in_reset_data", 2'd0, 0, 0);
        chk("in_reset_irq", {31'd0, irq0}, 0);
        in_port = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            in_port = tbl[k].in_val;
            if (tbl[k].do_wr) begin
                bif0.chipselect = 1'b1;
                bif0.write_n    = 1'b0;
                bif0.address    = tbl[k].waddr;
                bif0.writedata  = tbl[k].wdata;
            end
            for (int c = 0; c < tbl[k].waits; c++) begin
                @(negedge clk);
                bif0.chipselect = 1'b0;
                bif0.write_n    = 1'b1;
            end
            bif0.address = tbl[k].caddr;
            #1;
            chk({tbl[k].name, "/rd"},  bif0.readdata, tbl[k].rd0);
            chk({tbl[k].name, "/irq"}, {31'd0, irq0}, {31'd0, tbl[k].irq0});
            if (tbl[k].chk2) begin
                chk({tbl[k].name, "/rd_any"},  bif2.readdata, tbl[k].rd2);
                chk({tbl[k].name, "/irq_any"}, {31'd0, irq2}, {31'd0, tbl[k].irq2});
            end
        end

        // Reset in the middle of a debounce, then release with bit0 held high.
        @(negedge clk);
        in_port = 4'h1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        rd_chk("mid_rst_data", 2'd0, 0, 0);
        rd_chk("mid_rst_mask", 2'd2, 0, 0);
        rd_chk("mid_rst_cap",  2'd3, 0, 0);
        chk("mid_rst_irq", {31'd0, irq2}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        rd_chk("rel_data_m1", 2'd0, 0, 0);
        @(negedge clk);
        rd_chk("rel_data", 2'd0, 1, 1);
        rd_chk("rel_cap",  2'd3, 1, 1);
        chk("rel_irq", {31'd0, irq0}, 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) in_port = in_port ^ 4'($urandom);
            bif0.address = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                bif0.chipselect = 1'b1;
                bif0.write_n    = 1'b0;
                bif0.writedata  = $urandom;
            end else begin
                bif0.chipselect = 1'($urandom);
                bif0.write_n    = 1'b1;
            end
            #1;
            chk("rand_rd",      bif0.readdata, exp_rd(bif0.address, m_stab, m_mask, m_cap0));
            chk("rand_rd_any",  bif2.readdata, exp_rd(bif0.address, m_stab, m_mask, m_cap2));
            chk("rand_irq",     {31'd0, irq0}, {31'd0, |(m_cap0 & m_mask)});
            chk("rand_irq_any", {31'd0, irq2}, {31'd0, |(m_cap2 & m_mask)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
